// File: rtl/div_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package div_pkg;

  localparam int DW = 16;
  localparam int VW = 8;

  localparam logic [2:0] CNT_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_CALC = 3'b001,
    S_DONE = 3'b010,
    S_ERR  = 3'b011
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [VW-1:0] pr,
  input  logic          din,
  input  logic [VW-1:0] dv,
  output logic [VW-1:0] pr_nxt,
  output logic          qbit
);

  logic [VW:0] t;

  assign t    = {pr, din};
  assign qbit = (t >= {1'b0, dv});
  // Result is always < dv, so it fits back into VW bits in both branches.
  assign pr_nxt = qbit ? VW'(t - {1'b0, dv}) : t[VW-1:0];

endmodule

// File: rtl/seq_div_16x8.sv
// Sequential 16/8 restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIV_STATE_OUT_EN exposes the state register on state_out.
module seq_div_16x8
  import div_pkg::*;
#(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
) (
  input  logic          clk,
  input  logic          reset_a_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          done,
  output logic          busy,
  output logic          err
`ifdef DIV_STATE_OUT_EN
  ,output logic [2:0]   state_out
`endif
);

  state_e        state;
  logic [2:0]    cnt;
  logic [VW-1:0] dvsr;
  // Partial remainder kept as VW bits: the invariant pr < divisor keeps its 9th bit zero.
  logic [VW-1:0] pr;
  logic [VW-1:0] sr;
  logic [VW-1:0] pr_nxt;
  logic          qbit;
  logic          ovf;

  assign ovf = (divisor == '0) || (dividend[DW-1:VW] >= divisor);

  div_step u_step (
    .pr     (pr),
    .din    (sr[VW-1]),
    .dv     (dvsr),
    .pr_nxt (pr_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dvsr      <= '0;
      pr        <= '0;
      sr        <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (ovf) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state <= S_CALC;
              busy  <= 1'b1;
              err   <= 1'b0;
              dvsr  <= divisor;
              pr    <= dividend[DW-1:VW];
              sr    <= dividend[VW-1:0];
              cnt   <= '0;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (start) begin
            // Abort: partial results are dropped, published outputs untouched.
            state <= S_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            pr  <= pr_nxt;
            sr  <= {sr[VW-2:0], qbit};
            cnt <= cnt + 3'd1;
            if (cnt == CNT_LAST) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= {sr[VW-2:0], qbit};
              remainder <= pr_nxt;
            end
          end
        end
        default: begin
          state <= S_ERR;
          busy  <= 1'b0;
          err   <= 1'b1;
        end
      endcase
    end
  end

`ifdef DIV_STATE_OUT_EN
  assign state_out = state;
`endif

endmodule

// File: tb/tb_seq_div_16x8.sv
// Self-checking bench for seq_div_16x8: vector table, result scoreboard, handshake corner cases.
module tb_seq_div_16x8;

  logic        clk = 1'b0;
  logic        reset_a_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [7:0]  quotient, remainder;
  logic        done, busy, err;
`ifdef DIV_STATE_OUT_EN
  logic [2:0]  state_out;
`endif

  seq_div_16x8 dut (
    .clk       (clk),
    .reset_a_n (reset_a_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .err       (err)
`ifdef DIV_STATE_OUT_EN
    ,.state_out (state_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    bit          is_err;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  logic [7:0] last_q = '0, last_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_a_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    @(posedge clk); #1;
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns on the negedge of the DONE cycle; checks 9-clock latency and 8 busy cycles.
  task automatic wait_done(input string tag);
    int n = 0, nbusy = 0;
    bit seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_busy_cycles"}, nbusy, 8);
    chk({tag, "_err_low"}, 32'(err), 32'd0);
  endtask

  task automatic check_err(input string tag);
    int ndone = 0;
    @(negedge clk);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk({tag, "_no_done"}, ndone, 0);
    chk({tag, "_err_held"}, 32'(err), 32'd1);
    chk({tag, "_q_kept"}, 32'(quotient), 32'(last_q));
    chk({tag, "_r_kept"}, 32'(remainder), 32'(last_r));
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'd100,   8'd7,   8'd14,  8'd2,   1'b0});
    vecs.push_back('{16'd1000,  8'd10,  8'd100, 8'd0,   1'b0});
    vecs.push_back('{16'd300,   8'd0,   8'd0,   8'd0,   1'b1});
    vecs.push_back('{16'h0A00,  8'h0A,  8'd0,   8'd0,   1'b1});
    vecs.push_back('{16'd255,   8'd16,  8'd15,  8'd15,  1'b0});
    vecs.push_back('{16'hFEFF,  8'hFF,  8'd255, 8'd254, 1'b0});
    vecs.push_back('{16'd0,     8'd5,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{16'h00FF,  8'd1,   8'd255, 8'd0,   1'b0});
    vecs.push_back('{16'h0100,  8'd1,   8'd0,   8'd0,   1'b1});
    vecs.push_back('{16'h1234,  8'h13,  8'd245, 8'd5,   1'b0});
    vecs.push_back('{16'h7FFF,  8'h80,  8'd255, 8'd127, 1'b0});

    #12;
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef DIV_STATE_OUT_EN
    chk("rst_state", 32'(state_out), 32'd0);
`endif
    @(negedge clk);
    reset_a_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_err) begin
        start_op(vecs[i].dd, vecs[i].dv);
        check_err($sformatf("vec%0d", i));
      end else begin
        sb.push_back('{vecs[i].q, vecs[i].r});
        start_op(vecs[i].dd, vecs[i].dv);
        wait_done($sformatf("vec%0d", i));
      end
    end

    // Back-to-back: second start held during the DONE cycle.
    sb.push_back('{8'd100, 8'd0});
    start_op(16'd1000, 8'd10);
    wait_done("b2b_first");
    start = 1'b1; dividend = 16'hFEFF; divisor = 8'hFF;
    sb.push_back('{8'd255, 8'd254});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second");

    // Abort: start reasserted in the 4th CALC cycle.
    start_op(16'd100, 8'd7);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_err("abort");

    // Asynchronous reset between edges in the middle of CALC.
    start_op(16'd100, 8'd7);
    @(posedge clk);
    #3 reset_a_n = 1'b0;
    #1;
    chk("arst_quotient", 32'(quotient), 32'd0);
    chk("arst_remainder", 32'(remainder), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
`ifdef DIV_STATE_OUT_EN
    chk("arst_state", 32'(state_out), 32'd0);
`endif
    #2 reset_a_n = 1'b1;
    last_q = '0; last_r = '0;
    sb.push_back('{8'd15, 8'd15});
    start_op(16'd255, 8'd16);
    wait_done("post_rst");

`ifdef DIV_STATE_OUT_EN
    @(negedge clk);
    chk("walk_idle0", 32'(state_out), 32'd0);
    sb.push_back('{8'd14, 8'd2});
    start_op(16'd100, 8'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("walk_%0d", k), 32'(state_out), (k <= 8) ? 32'd1 : (k == 9) ? 32'd2 : 32'd0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
